lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
Memory-stage load/store unit that sits directly downstream of the execute-to-memory control pipeline register. It consumes the registered mem_read/mem_write/func3 controls plus the ALU address and store data. It runs a req/ack transaction on the data-memory bus and returns aligned, sign/zero-extended load data to writeback. While a transaction is outstanding it asserts lsu_stall, which holds the upstream pipeline registers.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT without bus_ack before a bus-timeout exception (≥2)
CNT_W, 7, width of timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_read_flip  in  1  load request from pipeline register
mem_write_flip  in  1  store request from pipeline register
func3_to_mem_flip  in  3  RV32I width/sign code
addr  in  32  effective byte address
store_data  in  32  rs2 value for stores
bus_req  out  1  transaction request (registered)
bus_we  out  1  1 = write
bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_wmask  out  4  byte-lane write enables
bus_ack  in  1  transaction complete; rdata valid same cycle for reads
bus_rdata  in  32  read word
load_data  out  32  formatted load result (registered)
lsu_stall  out  1  hold upstream stages
lsu_exc  out  1  one-cycle exception pulse
lsu_exc_cause  out  2  01 misaligned, 10 bus timeout, 11 illegal op

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_wmask, load_data, lsu_exc, lsu_exc_cause, and the counter all go to 0. This takes effect immediately, including mid-transaction; bus_req drops without waiting for ack.
- func3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are valid for loads only.
- Validity check in IDLE when mem_read_flip|mem_write_flip:
  - Both set, unlisted func3, or a store with 100/101 -> illegal, cause 11.
  - H/HU with addr[0]=1, or W with addr[1:0]!=0 -> misaligned, cause 01.
  - Illegal takes priority over misaligned.
  - On exception: lsu_exc=1 for exactly the next cycle (registered), no bus activity, lsu_stall never asserted, state stays IDLE.
- FSM states: IDLE, WAIT, DONE.
  - IDLE -> WAIT on a valid op. lsu_stall=1 combinationally in that cycle. bus_req, bus_we, bus_addr, bus_wdata, and bus_wmask are registered on that edge.
  - WAIT: bus_req=1 and all bus outputs held stable; lsu_stall=1; counter increments each cycle.
  - WAIT -> DONE on bus_ack. Loads capture the formatted rdata into load_data on that edge.
  - WAIT -> DONE on counter = TIMEOUT_CYCLES-1 with no ack. lsu_exc pulses with cause 10, load_data <= 0, and bus_req drops.
  - DONE: bus_req=0, lsu_stall=0 (pipeline advances), counter cleared. Always -> IDLE; no new op is accepted in DONE.
- Latency: op seen at cycle 0, bus_req high from cycle 1, ack at cycle k≥1, DONE at k+1. lsu_stall is high for cycles 0..k. Minimum stall is 2 cycles.
- bus_ack outside WAIT is ignored.
- Store formatting:
  - SB: wmask = 0001<<addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: wmask = addr[1] ? 1100 : 0011; wdata = {2{store_data[15:0]}}.
  - SW: wmask 1111; wdata = store_data.
- For loads, wmask = 0 and wdata = 0.
- Load formatting: select byte lane addr[1:0] or half lane addr[1], then sign-extend (B/H) or zero-extend (BU/HU). W passes through.
- load_data holds its value until the next load completes or a timeout occurs. Stores never change it.
- Inputs may change while stalled; the unit uses only values registered at IDLE->WAIT.

Test Plan:
- LW addr 0x100, ack on first req cycle, rdata 0xDEADBEEF -> bus_addr 0x100, wmask 0, lsu_stall high 2 cycles, load_data 0xDEADBEEF in DONE.
- LB addr 0x203, rdata 0x80FF_1234 -> load_data 0xFFFFFF80; same with LBU -> 0x00000080. LH addr 0x202, rdata 0x8001_0000 -> 0xFFFF8001.
- SB addr 0x302, store_data 0x000000AB, ack after 3 req cycles -> wmask 0100, wdata 0xABABABAB, bus outputs stable for all 3 cycles, load_data unchanged.
- SW addr 0x402 -> no bus_req, lsu_exc=1 for one cycle with cause 01, lsu_stall stays 0. mem_read and mem_write both 1 -> cause 11.
- LW with bus_ack never asserted, TIMEOUT_CYCLES=64 -> bus_req high exactly 64 cycles, then lsu_exc with cause 10, load_data=0, lsu_stall deasserts the following cycle.
- Assert reset=0 during WAIT (between edges) -> bus_req and lsu_stall go to 0 immediately. After release, the next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: validates the registered mem op, runs one req/ack
// bus transaction, and returns aligned, extended load data while stalling upstream.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_flip,
  input  logic        mem_write_flip,
  input  logic [2:0]  func3_to_mem_flip,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] load_data,
  output logic        lsu_stall,
  output logic        lsu_exc,
  output logic [1:0]  lsu_exc_cause,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  // Bus handshake: bus_req rises on the accepting edge and stays high, with every
  // bus output frozen, until the edge on which bus_ack is seen in WAIT (or timeout).

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_f3;
  logic [1:0]       op_lo;

  logic        op_req;
  logic        f3_known;
  logic        illegal;
  logic        misaligned;
  logic        accept;
  logic        timeout;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_fmt;
  logic [31:0] ld_shift;
  logic [15:0] ld_half;

  assign fsm_state = state;
  assign op_req    = mem_read_flip | mem_write_flip;

  always_comb begin
    f3_known = 1'b0;
    case (func3_to_mem_flip)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_known = 1'b1;
      default:                                f3_known = 1'b0;
    endcase
  end

  assign illegal = op_req &&
                   ((mem_read_flip && mem_write_flip) || !f3_known ||
                    (mem_write_flip && func3_to_mem_flip[2]));
  assign misaligned = op_req && !illegal &&
                      ((func3_to_mem_flip[1:0] == 2'b01 && addr[0]) ||
                       (func3_to_mem_flip == 3'b010 && addr[1:0] != 2'b00));
  assign accept    = (state == IDLE) && op_req && !illegal && !misaligned;
  assign lsu_stall = reset && (accept || state == WAIT);
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    st_mask = 4'b0000;
    st_data = 32'h0;
    case (func3_to_mem_flip[1:0])
      2'b00: begin
        st_mask = 4'b0001 << addr[1:0];
        st_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_mask = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{store_data[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = store_data;
      end
    endcase
  end

  // Lane selection uses the offset and width captured when the op was accepted.
  always_comb begin
    ld_shift = bus_rdata >> {op_lo, 3'b000};
    ld_half  = op_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ld_fmt   = bus_rdata;
    case (op_f3)
      3'b000:  ld_fmt = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'h0, ld_shift[7:0]};
      3'b101:  ld_fmt = {16'h0, ld_half};
      default: ld_fmt = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      op_f3         <= 3'b000;
      op_lo         <= 2'b00;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= 32'h0;
      bus_wdata     <= 32'h0;
      bus_wmask     <= 4'b0000;
      load_data     <= 32'h0;
      lsu_exc       <= 1'b0;
      lsu_exc_cause <= 2'b00;
    end else begin
      lsu_exc       <= 1'b0;
      lsu_exc_cause <= 2'b00;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            state     <= WAIT;
            bus_req   <= 1'b1;
            bus_we    <= mem_write_flip;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= mem_write_flip ? st_data : 32'h0;
            bus_wmask <= mem_write_flip ? st_mask : 4'b0000;
            op_f3     <= func3_to_mem_flip;
            op_lo     <= addr[1:0];
          end else if (op_req) begin
            lsu_exc       <= 1'b1;
            lsu_exc_cause <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
          end
        end
        WAIT: begin
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            cnt     <= '0;
            if (!bus_we) load_data <= ld_fmt;
          end else if (timeout) begin
            state         <= DONE;
            bus_req       <= 1'b0;
            cnt           <= '0;
            load_data     <= 32'h0;
            lsu_exc       <= 1'b1;
            lsu_exc_cause <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule
